// File: rtl/ifft_cp_inserter.sv
// Reorders natural-address IFFT samples into a ping-pong symbol buffer and streams each symbol with its cyclic prefix.
// Optional CP_NORM_EN applies the 1/N output scaling (round half up) with no added latency.
module ifft_cp_inserter #(
  parameter int WIDTH  = 26,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data_r,
  input  logic [WIDTH-1:0]  wr_data_i,
  input  logic [ADDR_W-1:0] cp_len,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [WIDTH-1:0]  out_data_r,
  output logic [WIDTH-1:0]  out_data_i,
  output logic              out_sop,
  output logic              out_eop,
  output logic              ovf
);

  // state  | meaning
  // IDLE   | waiting for the read bank to fill; latches cp_len on exit
  // CP     | issuing prefix reads, indices N-cp_len .. N-1
  // BODY   | issuing body reads, indices 0 .. N-1
  // DONE   | last body sample issued; its transfer frees the bank and may restart back-to-back
  typedef enum logic [1:0] {S_IDLE, S_CP, S_BODY, S_DONE} state_t;

  localparam int                N    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = '1;

  logic [WIDTH-1:0] r_mem_r [0:2*N-1];
  logic [WIDTH-1:0] r_mem_i [0:2*N-1];

  logic              r_wr_bank;
  logic [ADDR_W-1:0] r_wr_cnt;
  logic [1:0]        r_full;
  logic              r_ovf;

  state_t            r_state;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] r_cp;
  logic              r_rd_bank;
  logic              r_first;
  logic              r_out_valid;
  logic              r_out_sop;
  logic              r_out_eop;
  logic [WIDTH-1:0]  r_dout_r;
  logic [WIDTH-1:0]  r_dout_i;

  logic              w_wr_acc;
  logic              w_wr_last;
  logic [1:0]        w_full_set;
  logic [1:0]        w_full_clr;
  logic              w_adv;
  logic              w_free;
  logic              w_iss;
  logic              w_iss_bank;
  logic [ADDR_W-1:0] w_iss_idx;
  logic              w_iss_cp;
  logic              w_iss_sop;
  logic              w_iss_eop;

  // ---------------- write side ----------------
  assign w_wr_acc  = wr_valid && !r_full[r_wr_bank];
  assign w_wr_last = w_wr_acc && (r_wr_cnt == LAST);

  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem_r[{r_wr_bank, wr_addr}] <= wr_data_r;
      r_mem_i[{r_wr_bank, wr_addr}] <= wr_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_bank <= 1'b0;
      r_wr_cnt  <= '0;
      r_ovf     <= 1'b0;
    end else begin
      if (wr_valid && r_full[r_wr_bank])
        r_ovf <= 1'b1;
      if (w_wr_acc) begin
        r_wr_cnt <= r_wr_cnt + 1'b1;
        if (w_wr_last)
          r_wr_bank <= ~r_wr_bank;
      end
    end
  end

  // A bank freed this edge stays unwritable until the next edge because the writer sees the old flag.
  assign w_free        = r_out_valid && out_ready && r_out_eop;
  assign w_full_set[0] = w_wr_last && !r_wr_bank;
  assign w_full_set[1] = w_wr_last &&  r_wr_bank;
  assign w_full_clr[0] = w_free && !r_rd_bank;
  assign w_full_clr[1] = w_free &&  r_rd_bank;

  always_ff @(posedge clk) begin
    if (rst)
      r_full <= 2'b00;
    else
      r_full <= (r_full & ~w_full_clr) | w_full_set;
  end

  // ---------------- read side ----------------
  // The read data register is the output stage, so a stall simply freezes it.
  assign w_adv = !r_out_valid || out_ready;

  always_comb begin
    w_iss      = 1'b0;
    w_iss_bank = r_rd_bank;
    w_iss_idx  = r_idx;
    w_iss_cp   = (r_state == S_CP);
    case (r_state)
      S_CP, S_BODY: w_iss = w_adv;
      S_DONE: begin
        w_iss      = w_adv && r_full[~r_rd_bank];
        w_iss_bank = ~r_rd_bank;
        w_iss_cp   = (cp_len != '0);
        w_iss_idx  = w_iss_cp ? (~cp_len + 1'b1) : '0;
      end
      default: ;
    endcase
    w_iss_sop = (r_state == S_DONE) ? 1'b1 : r_first;
    w_iss_eop = !w_iss_cp && (w_iss_idx == LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_cp        <= '0;
      r_rd_bank   <= 1'b0;
      r_first     <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_sop   <= 1'b0;
      r_out_eop   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_full[r_rd_bank]) begin
            r_cp    <= cp_len;
            r_first <= 1'b1;
            r_idx   <= ~cp_len + 1'b1;
            r_state <= (cp_len == '0) ? S_BODY : S_CP;
          end
        end
        S_DONE: begin
          if (w_adv) begin
            r_rd_bank <= ~r_rd_bank;
            if (!w_iss)
              r_state <= S_IDLE;
          end
        end
        default: ;
      endcase

      if (w_iss) begin
        r_first <= 1'b0;
        r_idx   <= w_iss_idx + 1'b1;
        if (r_state == S_DONE)
          r_cp <= cp_len;
        if (w_iss_cp)
          r_state <= (w_iss_idx == LAST) ? S_BODY : S_CP;
        else
          r_state <= (w_iss_idx == LAST) ? S_DONE : S_BODY;
      end

      if (w_adv) begin
        r_out_valid <= w_iss;
        r_out_sop   <= w_iss && w_iss_sop;
        r_out_eop   <= w_iss && w_iss_eop;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout_r <= '0;
      r_dout_i <= '0;
    end else if (w_iss) begin
      r_dout_r <= r_mem_r[{w_iss_bank, w_iss_idx}];
      r_dout_i <= r_mem_i[{w_iss_bank, w_iss_idx}];
    end
  end

  // ---------------- output ----------------
`ifdef CP_NORM_EN
  localparam logic [WIDTH:0] HALF = {{(WIDTH-ADDR_W+1){1'b0}}, 1'b1, {(ADDR_W-1){1'b0}}};

  function automatic logic [WIDTH-1:0] f_norm(input logic [WIDTH-1:0] x);
    logic signed [WIDTH:0] s;
    s = $signed({x[WIDTH-1], x} + HALF);
    s = s >>> ADDR_W;
    return s[WIDTH-1:0];
  endfunction

  assign out_data_r = f_norm(r_dout_r);
  assign out_data_i = f_norm(r_dout_i);
`else
  assign out_data_r = r_dout_r;
  assign out_data_i = r_dout_i;
`endif

  assign out_valid = r_out_valid;
  assign out_sop   = r_out_sop;
  assign out_eop   = r_out_eop;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_ifft_cp_inserter.sv
// Directed bench for ifft_cp_inserter: frame order, CP handling, back-to-back frames, overflow, stalls and reset.
module tb_ifft_cp_inserter;
  localparam int WIDTH  = 26;
  localparam int ADDR_W = 11;
  localparam int N      = 2048;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data_r, wr_data_i;
  logic [ADDR_W-1:0] cp_len;
  logic              out_ready;
  logic              out_valid;
  logic [WIDTH-1:0]  out_data_r, out_data_i;
  logic              out_sop, out_eop;
  logic              ovf;

  always #5 clk = ~clk;

  ifft_cp_inserter #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data_r(wr_data_r), .wr_data_i(wr_data_i),
    .cp_len(cp_len), .out_ready(out_ready),
    .out_valid(out_valid), .out_data_r(out_data_r), .out_data_i(out_data_i),
    .out_sop(out_sop), .out_eop(out_eop), .ovf(ovf)
  );

  typedef struct {
    logic [10:0] addr;
    logic [25:0] din_r, din_i;
    logic [25:0] ne_r, ne_i;   // expected output when normalization is built in
  } vec_t;

  typedef struct {
    logic [25:0] r, i;
    logic        sop, eop;
    int          cyc;
  } cap_t;

  cap_t        cap_q[$];
  vec_t        vt[6];
  logic [25:0] ref_r [3][N];
  logic [25:0] ref_i [3][N];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc   = 0;
  bit          rdy_rand = 1'b0;
  logic        rdy_fix  = 1'b0;
  logic        prev_stall = 1'b0;
  logic [53:0] prev_word;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [25:0] expv(input logic [25:0] x);
`ifdef CP_NORM_EN
    logic signed [26:0] t;
    t = $signed({x[25], x}) + 27'sd1024;
    t = t >>> 11;
    return t[25:0];
`else
    return x;
`endif
  endfunction

  function automatic logic [10:0] brev(input int k);
    logic [10:0] a, r;
    a = 11'(k);
    for (int b = 0; b < 11; b++) r[b] = a[10-b];
    return r;
  endfunction

  // Output monitor: captures transfers and checks hold-stability on stalled cycles.
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stall)
        check("stall_hold", 64'({out_valid, out_sop, out_eop, out_data_r, out_data_i}),
              64'({1'b1, prev_word}));
      if (out_valid && out_ready)
        cap_q.push_back('{out_data_r, out_data_i, out_sop, out_eop, cyc});
      prev_stall = out_valid && !out_ready;
      prev_word  = {out_sop, out_eop, out_data_r, out_data_i};
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fix;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wr_valid = 1'b0;
    step(); step(); step();
    cap_q.delete();
    rst = 1'b0;
  endtask

  task automatic write_symbol(input int s, input bit br, input int nw);
    logic [10:0] a;
    for (int k = 0; k < nw; k++) begin
      a = br ? brev(k) : 11'(k);
      wr_valid  = 1'b1;
      wr_addr   = a;
      wr_data_r = ref_r[s][a];
      wr_data_i = ref_i[s][a];
      step();
    end
    wr_valid = 1'b0;
  endtask

  task automatic wait_samples(input string nm, input int cnt, input int budget);
    int t = 0;
    while (cap_q.size() < cnt && t < budget) begin
      step();
      t++;
    end
    repeat (30) step();
    check({nm, "_count"}, 64'(cap_q.size()), 64'(cnt));
  endtask

  task automatic check_frame(input string nm, input int base, input int s, input int cp);
    int bad = 0, first_bad = -1, sop_bad = 0, eop_bad = 0, idx;
    int len = cp + N;
    for (int j = 0; j < len; j++) begin
      if (base + j >= cap_q.size()) begin
        bad++; sop_bad++; eop_bad++;
        if (first_bad < 0) first_bad = j;
        continue;
      end
      idx = (j < cp) ? (N - cp + j) : (j - cp);
      if (cap_q[base+j].r !== expv(ref_r[s][idx]) || cap_q[base+j].i !== expv(ref_i[s][idx])) begin
        bad++;
        if (first_bad < 0) first_bad = j;
      end
      if (cap_q[base+j].sop !== (j == 0)) sop_bad++;
      if (cap_q[base+j].eop !== (j == len - 1)) eop_bad++;
    end
    check($sformatf("%s_data_errors(first_pos=%0d)", nm, first_bad), 64'(bad), 64'(0));
    check({nm, "_sop_errors"}, 64'(sop_bad), 64'(0));
    check({nm, "_eop_errors"}, 64'(eop_bad), 64'(0));
  endtask

  task automatic check_gap(input string nm, input int base, input int len);
    if (base + len <= cap_q.size())
      check(nm, 64'(cap_q[base+len-1].cyc - cap_q[base].cyc), 64'(len - 1));
    else
      check(nm, 64'(cap_q.size()), 64'(base + len));
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data_r = '0; wr_data_i = '0;
    cp_len = 11'd144; out_ready = 1'b0;

    vt[0] = '{11'd0,    26'(2048),  26'(-1024), 26'(1),  26'(0)};
    vt[1] = '{11'd1,    26'(1023),  26'(-1025), 26'(0),  26'(-1)};
    vt[2] = '{11'd2,    26'(1024),  26'(0),     26'(1),  26'(0)};
    vt[3] = '{11'd3,    26'(-1024), 26'(2048),  26'(0),  26'(1)};
    vt[4] = '{11'd4,    26'(-1025), 26'(1023),  26'(-1), 26'(0)};
    vt[5] = '{11'd2047, 26'(1024),  26'(-1025), 26'(1),  26'(-1)};

    for (int k = 0; k < N; k++) begin
      ref_r[0][k] = 26'(k);          ref_i[0][k] = 26'(-k);
      ref_r[1][k] = 26'(100000 + k); ref_i[1][k] = 26'(-(3 * k + 7));
      ref_r[2][k] = 26'(200000 + k); ref_i[2][k] = 26'(5 * k);
    end
    for (int v = 0; v < 6; v++) begin
      ref_r[2][vt[v].addr] = vt[v].din_r;
      ref_i[2][vt[v].addr] = vt[v].din_i;
    end

    do_reset();
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_sop",   64'(out_sop),   64'(0));
    check("rst_out_eop",   64'(out_eop),   64'(0));
    check("rst_out_data_r", 64'(out_data_r), 64'(0));
    check("rst_out_data_i", 64'(out_data_i), 64'(0));
    check("rst_ovf",       64'(ovf),       64'(0));

    // natural order, cp 144
    rdy_fix = 1'b1;
    write_symbol(0, 1'b0, N);
    wait_samples("nat", 2192, 3000);
    check_frame("nat", 0, 0, 144);
    check_gap("nat_gap", 0, 2192);
    if (cap_q.size() > 0)
      check("nat_first_r", 64'(cap_q[0].r), 64'(expv(26'd1904)));
    else
      check("nat_first_r", 64'(cap_q.size()), 64'(1));
    check("nat_ovf", 64'(ovf), 64'(0));

    // bit-reversed order gives the same stream
    cap_q.delete();
    write_symbol(0, 1'b1, N);
    wait_samples("brev", 2192, 3000);
    check_frame("brev", 0, 0, 144);

    // cp 0, with the normalization vectors embedded in the symbol
    cap_q.delete();
    cp_len = 11'd0;
    write_symbol(2, 1'b0, N);
    wait_samples("cp0", N, 3000);
    check_frame("cp0", 0, 2, 0);
    for (int v = 0; v < 6; v++) begin
      logic [25:0] er, ei;
`ifdef CP_NORM_EN
      er = vt[v].ne_r; ei = vt[v].ne_i;
`else
      er = vt[v].din_r; ei = vt[v].din_i;
`endif
      check($sformatf("vec%0d_r", v),
            64'((int'(vt[v].addr) < cap_q.size()) ? cap_q[vt[v].addr].r : 26'bx), 64'(er));
      check($sformatf("vec%0d_i", v),
            64'((int'(vt[v].addr) < cap_q.size()) ? cap_q[vt[v].addr].i : 26'bx), 64'(ei));
    end

    // two symbols buffered under stall, third dropped, then back-to-back drain
    cap_q.delete();
    cp_len = 11'd144;
    rdy_fix = 1'b0;
    write_symbol(0, 1'b0, N);
    write_symbol(1, 1'b0, N);
    write_symbol(2, 1'b0, 1000);
    check("b2b_ovf_set", 64'(ovf), 64'(1));
    check("b2b_valid_stalled", 64'(out_valid), 64'(1));
    check("b2b_nothing_sent", 64'(cap_q.size()), 64'(0));
    step(); step();
    rdy_fix = 1'b1;
    wait_samples("b2b", 2 * 2192, 6000);
    check_frame("b2b_a", 0, 0, 144);
    check_frame("b2b_b", 2192, 1, 144);
    check_gap("b2b_gap", 0, 2 * 2192);
    check("b2b_ovf_sticky", 64'(ovf), 64'(1));

    // dropped writes must not have advanced the write counter
    cap_q.delete();
    write_symbol(2, 1'b0, N);
    wait_samples("after_ovf", 2192, 3000);
    check_frame("after_ovf", 0, 2, 144);

    // reset clears ovf and a partial symbol; then random backpressure
    do_reset();
    check("rst2_ovf", 64'(ovf), 64'(0));
    check("rst2_valid", 64'(out_valid), 64'(0));
    rdy_rand = 1'b1;
    write_symbol(1, 1'b0, 1000);
    do_reset();
    write_symbol(0, 1'b0, N);
    wait_samples("rand", 2192, 8000);
    check_frame("rand", 0, 0, 144);
    rdy_rand = 1'b0;

    // maximum cp, cp_len changed after the frame has latched it
    cap_q.delete();
    rdy_fix = 1'b1;
    cp_len = 11'd2047;
    write_symbol(1, 1'b0, N);
    step();
    cp_len = 11'd5;
    wait_samples("cpmax", 2047 + N, 6000);
    check_frame("cpmax", 0, 1, 2047);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ifft_cp_inserter.md
# ifft_cp_inserter

Output-side consumer for the 2048-point SDF IFFT pipeline. It accepts IFFT samples in the pipeline's native output order, each tagged with its natural-order memory address. It reorders them into a ping-pong symbol buffer, then streams each completed symbol in natural order with the cyclic prefix prepended, under a valid/ready handshake. It sits directly after the IFFT top and feeds the time-domain transmit path.

## Interface
- WIDTH, 26, sample component width (two's complement), real and imaginary
- ADDR_W, 11, address width; N = 2^ADDR_W points per symbol
- clk  in  1  clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- wr_valid  in  1  IFFT sample valid (driven by IFFT READy_out)
- wr_addr  in  ADDR_W  natural-order index of the sample (IFFT memory address)
- wr_data_r / wr_data_i  in  WIDTH  IFFT sample
- cp_len  in  ADDR_W  CP length in samples, 0..N-1 (144 normal, 512 extended)
- out_ready  in  1  downstream accepts sample
- out_valid  out  1  out_data valid
- out_data_r / out_data_i  out  WIDTH  time-domain sample
- out_sop / out_eop  out  1  first / last sample of a CP+symbol frame, qualified by out_valid
- ovf  out  1  sticky overflow flag

## Operation
- Buffer has two banks (A, B) of N complex entries. Each bank has a full flag. The write pointer starts at A.
- Write side: each wr_valid stores the sample at [wr_bank][wr_addr] and increments a write counter. The Nth write sets full[wr_bank], clears the counter and toggles wr_bank. Address order is arbitrary; only the count defines symbol completion.
- A write that arrives while full[wr_bank]=1 is dropped and sets ovf=1. ovf is cleared only by rst. The write counter does not advance on a dropped write.
- Read FSM states:
  - IDLE: on full[rd_bank] -> CP, or -> BODY if the latched cp_len is 0. cp_len is latched on leaving IDLE or on the back-to-back restart.
  - CP: reads indices N-cp_len .. N-1 -> BODY.
  - BODY: reads indices 0 .. N-1.
- End of a frame: on the transfer of index N-1 in BODY:
  - Clear full[rd_bank] and toggle rd_bank.
  - If full of the new bank is already set, go directly to CP/BODY for the next frame (back-to-back, no idle cycle). Otherwise go to IDLE.
- Frame flags: out_sop marks the first transferred sample of a frame (the first CP sample, or index 0 when cp_len=0). out_eop marks BODY index N-1.
- Simultaneous events:
  - A write completing bank X in the same cycle the reader frees bank Y: both take effect.
  - A write into a bank in the same cycle that bank's full flag clears: the bank is writable next cycle, not this one. That write is treated as overflow only if full was set at that clock edge.
- Reset mid-operation: clear all counters, full flags, bank pointers, FSM (-> IDLE) and outputs. Any partial or buffered symbol is discarded. Memory contents are not cleared.

## Timing
- Reset values: out_valid=0, out_sop=0, out_eop=0, out_data_r/i=0, ovf=0.
- Let E0 be the clock edge of the Nth write. full is visible after E0, the FSM leaves IDLE at E1, and out_valid rises after E2 with the first frame sample.
- Transfer occurs when out_valid && out_ready. With out_ready held high, one sample is transferred per cycle with no bubbles, including across back-to-back frames.
- While out_valid && !out_ready: out_data, out_sop and out_eop hold stable, and the read address does not advance.
- Memory reads are synchronous with one-cycle read latency. Prefetch or skid logic must preserve the throughput and stability rules above.
- Frame length is cp_len + N transfers.

## Configuration
- CP_NORM_EN defined: each output component = (x + 2^(ADDR_W-1)) >>> ADDR_W (arithmetic shift, round half up), sign-extended to WIDTH. This applies the 1/N IFFT normalization. No change to latency.
- CP_NORM_EN undefined: samples pass through unmodified.

## Test plan
- Natural-order writes: wr_addr 0..2047, data_r = index, cp_len=144, out_ready=1 -> 2192 samples: 1904..2047 then 0..2047. out_sop on 1904, out_eop on the final 2047, ovf=0.
- Bit-reversed wr_addr order with data_r = wr_addr -> output sequence identical to the natural-order case.
- cp_len=0 -> exactly 2048 samples. out_sop and the first sample (index 0) coincide.
- Three symbols written back-to-back with out_ready=0 -> symbols 1 and 2 are buffered, symbol 3 writes are dropped, ovf=1. After releasing out_ready, two frames stream contiguously with no idle cycle between eop and sop.
- Randomized out_ready with a 50% duty cycle -> output sequence is unchanged from case 1, and data is stable on every stalled cycle.
- CP_NORM_EN defined:

  | Input | Output |
  |---|---|
  | 2048 | 1 |
  | 1023 | 0 |
  | 1024 | 1 |
  | -1024 | 0 |
  | -1025 | -1 |
